// File: rtl/video_timing_detector.sv
// rtl/video_timing_detector.sv - measures incoming raster timing and locks onto it
//
// Watches hsync/vsync/de on the pixel clock. It measures the line length, the
// frame length, the active pixels per line and the active lines per frame. It
// asserts locked once LOCK_FRAMES consecutive identical clean frames are seen.
//
// Ports:
//   pixel_clk, rst_n    pixel clock; asynchronous active-low reset
//   hsync, vsync        sync inputs; active level set by HS_POL / VS_POL
//   de                  data enable, active-high
//   h_total, v_total    locked line length (clocks) / frame length (lines)
//   h_active, v_active  locked active pixels per line / active lines per frame
//   locked              measurement outputs valid and stable
//   frame_start         one-cycle pulse per vsync leading edge
//   timeout             one-cycle pulse when the line or frame counter saturates

module video_timing_detector #(
  parameter int unsigned CW          = 12,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter bit          HS_POL      = 1'b1,
  parameter bit          VS_POL      = 1'b1
) (
  input  logic          pixel_clk,
  input  logic          rst_n,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          de,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] v_active,
  output logic          locked,
  output logic          frame_start,
  output logic          timeout
);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_e;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [3:0]    LOCK_N  = 4'(LOCK_FRAMES);

  // Input stage. Syncs are normalised as they are registered, so the reset
  // value 0 means "not asserted" for either polarity and no edge is seen at reset.
  logic hs_s_q, vs_s_q, de_s_q;
  logic hs_p_q, vs_p_q, de_p_q;
  logic hs_le_q, vs_le_q, de_fe_q, de_a_q;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_s_q  <= 1'b0;
      vs_s_q  <= 1'b0;
      de_s_q  <= 1'b0;
      hs_p_q  <= 1'b0;
      vs_p_q  <= 1'b0;
      de_p_q  <= 1'b0;
      hs_le_q <= 1'b0;
      vs_le_q <= 1'b0;
      de_fe_q <= 1'b0;
      de_a_q  <= 1'b0;
    end else begin
      hs_s_q  <= (hsync == HS_POL);
      vs_s_q  <= (vsync == VS_POL);
      de_s_q  <= de;
      hs_p_q  <= hs_s_q;
      vs_p_q  <= vs_s_q;
      de_p_q  <= de_s_q;
      hs_le_q <= hs_s_q & ~hs_p_q;
      vs_le_q <= vs_s_q & ~vs_p_q;
      de_fe_q <= ~de_s_q & de_p_q;
      de_a_q  <= de_s_q;
    end
  end

  state_e        state_q, state_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d, de_cnt_q, de_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d, va_cnt_q, va_cnt_d;
  logic [CW-1:0] ref_h_q, ref_h_d, ref_de_q, ref_de_d;
  logic          ref_h_vld_q, ref_h_vld_d, ref_de_vld_q, ref_de_vld_d;
  logic          bad_q, bad_d, skip_q, skip_d, de_seen_q, de_seen_d;
  logic [CW-1:0] cand_h_q, cand_h_d, cand_v_q, cand_v_d;
  logic [CW-1:0] cand_de_q, cand_de_d, cand_va_q, cand_va_d;
  logic [3:0]    match_q, match_d;
  logic [CW-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
  logic [CW-1:0] h_active_q, h_active_d, v_active_q, v_active_d;
  logic          locked_q, locked_d, frame_start_q, frame_start_d;
  logic          timeout_q, timeout_d;
  logic          meas_eq;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      h_cnt_q       <= '0;
      de_cnt_q      <= '0;
      v_cnt_q       <= '0;
      va_cnt_q      <= '0;
      ref_h_q       <= '0;
      ref_de_q      <= '0;
      ref_h_vld_q   <= 1'b0;
      ref_de_vld_q  <= 1'b0;
      bad_q         <= 1'b0;
      skip_q        <= 1'b0;
      de_seen_q     <= 1'b0;
      cand_h_q      <= '0;
      cand_v_q      <= '0;
      cand_de_q     <= '0;
      cand_va_q     <= '0;
      match_q       <= '0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      h_active_q    <= '0;
      v_active_q    <= '0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      de_cnt_q      <= de_cnt_d;
      v_cnt_q       <= v_cnt_d;
      va_cnt_q      <= va_cnt_d;
      ref_h_q       <= ref_h_d;
      ref_de_q      <= ref_de_d;
      ref_h_vld_q   <= ref_h_vld_d;
      ref_de_vld_q  <= ref_de_vld_d;
      bad_q         <= bad_d;
      skip_q        <= skip_d;
      de_seen_q     <= de_seen_d;
      cand_h_q      <= cand_h_d;
      cand_v_q      <= cand_v_d;
      cand_de_q     <= cand_de_d;
      cand_va_q     <= cand_va_d;
      match_q       <= match_d;
      h_total_q     <= h_total_d;
      v_total_q     <= v_total_d;
      h_active_q    <= h_active_d;
      v_active_q    <= v_active_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    de_cnt_d      = de_cnt_q;
    v_cnt_d       = v_cnt_q;
    va_cnt_d      = va_cnt_q;
    ref_h_d       = ref_h_q;
    ref_de_d      = ref_de_q;
    ref_h_vld_d   = ref_h_vld_q;
    ref_de_vld_d  = ref_de_vld_q;
    bad_d         = bad_q;
    skip_d        = skip_q;
    de_seen_d     = de_seen_q | de_a_q;
    cand_h_d      = cand_h_q;
    cand_v_d      = cand_v_q;
    cand_de_d     = cand_de_q;
    cand_va_d     = cand_va_q;
    match_d       = match_q;
    h_total_d     = h_total_q;
    v_total_d     = v_total_q;
    h_active_d    = h_active_q;
    v_active_d    = v_active_q;
    frame_start_d = 1'b0;
    timeout_d     = 1'b0;
    meas_eq       = 1'b0;

    if (hs_le_q)                 h_cnt_d = CW'(1);
    else if (h_cnt_q != CNT_MAX) h_cnt_d = h_cnt_q + CW'(1);

    if (de_fe_q)                               de_cnt_d = '0;
    else if (de_a_q && de_cnt_q != CNT_MAX)    de_cnt_d = de_cnt_q + CW'(1);

    // Line close is handled before frame close, so a coincident hsync edge
    // contributes its line to the frame that is ending.
    if (hs_le_q) begin
      if (v_cnt_q != CNT_MAX)              v_cnt_d  = v_cnt_q + CW'(1);
      if (de_seen_q && va_cnt_q != CNT_MAX) va_cnt_d = va_cnt_q + CW'(1);
      de_seen_d = de_a_q;
      if (skip_q) begin
        skip_d = 1'b0;
      end else if (!ref_h_vld_q) begin
        ref_h_d     = h_cnt_q;
        ref_h_vld_d = 1'b1;
      end else if (h_cnt_q != ref_h_q) begin
        bad_d = 1'b1;
      end
    end

    if (de_fe_q) begin
      if (!ref_de_vld_q) begin
        ref_de_d     = de_cnt_q;
        ref_de_vld_d = 1'b1;
      end else if (de_cnt_q != ref_de_q) begin
        bad_d = 1'b1;
      end
    end

    meas_eq = (ref_h_d == cand_h_q) && (v_cnt_d == cand_v_q) &&
              (ref_de_d == cand_de_q) && (va_cnt_d == cand_va_q);

    if (vs_le_q) begin
      frame_start_d = 1'b1;
      if (state_q == SEARCH) begin
        state_d = VERIFY;
        match_d = '0;
        skip_d  = 1'b1;
      end else if (!(state_q == LOCKED && !bad_d && meas_eq)) begin
        state_d = VERIFY;
        if (bad_d) begin
          match_d = '0;
        end else if (meas_eq) begin
          match_d = match_q + 4'd1;
        end else begin
          cand_h_d  = ref_h_d;
          cand_v_d  = v_cnt_d;
          cand_de_d = ref_de_d;
          cand_va_d = va_cnt_d;
          match_d   = 4'd1;
        end
        if (match_d == LOCK_N) state_d = LOCKED;
      end
      v_cnt_d      = '0;
      va_cnt_d     = '0;
      ref_h_vld_d  = 1'b0;
      ref_de_vld_d = 1'b0;
      bad_d        = 1'b0;
    end

    // Fires only on the cycle a counter first hits its ceiling; the counter then
    // sits saturated, so the pulse is not repeated.
    if ((h_cnt_d == CNT_MAX && h_cnt_q != CNT_MAX) ||
        (v_cnt_d == CNT_MAX && v_cnt_q != CNT_MAX)) begin
      timeout_d = 1'b1;
      match_d   = '0;
      state_d   = SEARCH;
    end

    if (state_d == LOCKED && state_q != LOCKED) begin
      h_total_d  = cand_h_d;
      v_total_d  = cand_v_d;
      h_active_d = cand_de_d;
      v_active_d = cand_va_d;
    end
    locked_d = (state_d == LOCKED);
  end

  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign h_active    = h_active_q;
  assign v_active    = v_active_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign timeout     = timeout_q;

endmodule
